// File: rtl/tff_bank.sv
// tff_bank: bank of WIDTH T flip-flops with toggle, up-count, down-count and load modes.
// Define TFF_BANK_TOGGLE_CNT_EN to add the saturating toggle_cnt activity counter.
module tff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] toggled,
    output logic             wrap,
    output logic             tc
`ifdef TFF_BANK_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DN     = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_t;

    mode_t            modeSel;
    logic [WIDTH-1:0] upMask;
    logic [WIDTH-1:0] dnMask;
    logic             upCarry;
    logic             dnBorrow;
    logic [WIDTH-1:0] flipMask;
    logic             wrapNext;
    logic             qAllOnes;
    logic             qZero;

    if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_bad_params
        $error("tff_bank: WIDTH must be 2..32 and CNT_W at least 1");
    end

    assign modeSel  = mode_t'(mode);
    assign qAllOnes = &q;
    assign qZero    = ~|q;

    // Ripple toggle conditions: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        upMask   = '0;
        dnMask   = '0;
        upCarry  = t[0];
        dnBorrow = t[0];
        for (int i = 0; i < WIDTH; i++) begin
            upMask[i] = upCarry;
            dnMask[i] = dnBorrow;
            upCarry   = upCarry & q[i];
            dnBorrow  = dnBorrow & ~q[i];
        end
    end

    // Every update is expressed as a flip mask, so toggled is simply the mask itself.
    always_comb begin
        flipMask = '0;
        wrapNext = 1'b0;
        if (clear) begin
            flipMask = q ^ RESET_VAL;
        end else if (en) begin
            case (modeSel)
                MODE_TOGGLE: flipMask = t;
                MODE_UP: begin
                    flipMask = upMask;
                    wrapNext = t[0] & qAllOnes;
                end
                MODE_DN: begin
                    flipMask = dnMask;
                    wrapNext = t[0] & qZero;
                end
                MODE_LOAD:   flipMask = q ^ load_val;
                default:     flipMask = '0;
            endcase
        end
    end

    assign tc = ((modeSel == MODE_UP) && qAllOnes) || ((modeSel == MODE_DN) && qZero);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q       <= RESET_VAL;
            toggled <= '0;
            wrap    <= 1'b0;
        end else begin
            q       <= q ^ flipMask;
            toggled <= flipMask;
            wrap    <= wrapNext;
        end
    end

`ifdef TFF_BANK_TOGGLE_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Counts edges that change at least one bit, sticking at the maximum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_cnt <= '0;
        end else if (clear) begin
            toggle_cnt <= '0;
        end else if ((|flipMask) && (toggle_cnt != CntMax)) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tff_bank.sv
// tb_tff_bank: table-driven checks of tff_bank (WIDTH=8) plus reset and activity-counter sequences.
module tb_tff_bank;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic [7:0] load_val;
    logic       clear;
    logic [7:0] q;
    logic [7:0] toggled;
    logic       wrap;
    logic       tc;
`ifdef TFF_BANK_TOGGLE_CNT_EN
    logic [7:0] toggle_cnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic       clr;
        logic       en;
        logic [1:0] mode;
        logic [7:0] t;
        logic [7:0] lv;
        logic [7:0] q;
        logic [7:0] tog;
        logic       wrap;
        logic       tc;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    tff_bank #(
        .WIDTH    (8),
        .RESET_VAL(8'h00),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .t       (t),
        .load_val(load_val),
        .clear   (clear),
        .q       (q),
        .toggled (toggled),
        .wrap    (wrap),
        .tc      (tc)
`ifdef TFF_BANK_TOGGLE_CNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        clear    = v.clr;
        en       = v.en;
        mode     = v.mode;
        t        = v.t;
        load_val = v.lv;
        @(posedge clk);
        #1;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".q"}, 32'(q), 32'(v.q));
        checkOutput({tag, ".toggled"}, 32'(toggled), 32'(v.tog));
        checkOutput({tag, ".wrap"}, 32'(wrap), 32'(v.wrap));
        checkOutput({tag, ".tc"}, 32'(tc), 32'(v.tc));
    endtask

    initial begin
        // clr en mode t lv | q tog wrap tc    (sequence starts from q=0x00)
        vecs[0]  = '{1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b11, 8'h00, 8'hFE, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 8'hFE, 8'h01, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 8'hFE, 8'h00, 8'hFE, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 8'hFF, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 8'h03, 8'h00, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 8'h03, 8'h01, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 8'h04, 8'h07, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'b11, 8'hFF, 8'h81, 8'h81, 8'h85, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h3C, 8'h00, 8'h81, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'hFF, 8'hFF, 8'hC3, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 2'b10, 8'h01, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b1, 2'b01, 8'h01, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};

        // Reset held with the clock running and toggles requested.
        reset_n  = 1'b0;
        en       = 1'b1;
        mode     = 2'b00;
        t        = 8'hFF;
        load_val = 8'h00;
        clear    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.q", 32'(q), 32'h00);
        checkOutput("reset.toggled", 32'(toggled), 32'h00);
        checkOutput("reset.wrap", 32'(wrap), 32'h0);
`ifdef TFF_BANK_TOGGLE_CNT_EN
        checkOutput("reset.cnt", 32'(toggle_cnt), 32'h00);
`endif

        // Release between edges: nothing moves until the next rising edge.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("release.q", 32'(q), 32'h00);
        checkOutput("release.toggled", 32'(toggled), 32'h00);

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Fresh reset, then a long run of single-bit toggles.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        clear   = 1'b0;
        en      = 1'b1;
        mode    = 2'b00;
        t       = 8'h01;
`ifdef TFF_BANK_TOGGLE_CNT_EN
        for (int i = 1; i <= 301; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) checkOutput("cnt.after5", 32'(toggle_cnt), 32'd5);
        end
        checkOutput("cnt.saturated", 32'(toggle_cnt), 32'hFF);
`else
        repeat (7) @(posedge clk);
        #1;
`endif
        checkOutput("run.q", 32'(q), 32'h01);
        checkOutput("run.toggled", 32'(toggled), 32'h01);

        // Asynchronous assertion mid-cycle clears everything immediately.
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset.q", 32'(q), 32'h00);
        checkOutput("midreset.toggled", 32'(toggled), 32'h00);
        checkOutput("midreset.wrap", 32'(wrap), 32'h0);
`ifdef TFF_BANK_TOGGLE_CNT_EN
        checkOutput("midreset.cnt", 32'(toggle_cnt), 32'h00);
`endif

        // First edge after deassertion is processed normally.
        @(negedge clk);
        reset_n = 1'b1;
        t       = 8'h03;
        @(posedge clk);
        #1;
        checkOutput("postreset.q", 32'(q), 32'h03);
        checkOutput("postreset.toggled", 32'(toggled), 32'h03);
`ifdef TFF_BANK_TOGGLE_CNT_EN
        checkOutput("postreset.cnt", 32'(toggle_cnt), 32'h01);
        clear = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("clear.cnt", 32'(toggle_cnt), 32'h00);
        clear = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
